// File: rtl/timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and DIV field placement for the
// memory-mapped timer peripheral.
package timer_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;

  // Byte offsets inside the 32-byte window; bits [4:3] select the register
  localparam logic [4:0] CTRL_OFF   = 5'h00;
  localparam logic [4:0] PERIOD_OFF = 5'h08;
  localparam logic [4:0] COUNT_OFF  = 5'h10;
  localparam logic [4:0] STATUS_OFF = 5'h18;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_AUTO_BIT = 1;
  localparam int unsigned CTRL_IEN_BIT  = 2;
  localparam int unsigned DIV_LSB       = 16;

  localparam int unsigned STATUS_MATCH_BIT = 0;
  localparam int unsigned STATUS_OVR_BIT   = 1;

  function automatic int unsigned div_msb(input int unsigned prescale_width);
    return DIV_LSB + prescale_width - 1;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock by div+1 while enabled; tick is high on the cycle pre == div.
module timer_prescaler #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);

  logic [WIDTH-1:0] pre_q;
  logic [WIDTH-1:0] pre_d;

  assign tick = enable && (pre_q == div);

  always_comb begin
    pre_d = pre_q + WIDTH'(1);
    if (!enable || restart || tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/timer_peripheral.sv
// Bus-responder timer: decodes a 32-byte window, holds CTRL/PERIOD/COUNT/STATUS,
// counts prescaled ticks against PERIOD and raises a level match interrupt.
module timer_peripheral
  import timer_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_0001_0000,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_write,
  input  logic              mem_read,
  output logic [DATA_W-1:0] read_data,
  output logic              read_drive,
  output logic              irq
);

  localparam int unsigned DIV_MSB    = div_msb(PRESCALE_WIDTH);
  localparam logic [1:0]  CTRL_IDX   = CTRL_OFF[4:3];
  localparam logic [1:0]  PERIOD_IDX = PERIOD_OFF[4:3];
  localparam logic [1:0]  COUNT_IDX  = COUNT_OFF[4:3];
  localparam logic [1:0]  STATUS_IDX = STATUS_OFF[4:3];

  logic                      en_q, en_d;
  logic                      auto_q, auto_d;
  logic                      ien_q, ien_d;
  logic [PRESCALE_WIDTH-1:0] div_q, div_d;
  logic [DATA_W-1:0]         period_q, period_d;
  logic [DATA_W-1:0]         count_q, count_d;
  logic                      match_q, match_d;
  logic                      ovr_q, ovr_d;

  logic       sel;
  logic [1:0] reg_idx;
  logic       wr_ctrl, wr_period, wr_count, wr_status;
  logic       tick, tick_eff, restart;
  logic       unused_addr_bits;

  // Byte lane within a register is irrelevant: every access is a full 64-bit word
  assign unused_addr_bits = ^address[2:0];

  assign sel       = (address[63:5] == BASE_ADDR[63:5]);
  assign reg_idx   = address[4:3];
  assign wr_ctrl   = sel && mem_write && (reg_idx == CTRL_IDX);
  assign wr_period = sel && mem_write && (reg_idx == PERIOD_IDX);
  assign wr_count  = sel && mem_write && (reg_idx == COUNT_IDX);
  assign wr_status = sel && mem_write && (reg_idx == STATUS_IDX);

  // A COUNT write or a disabling CTRL write swallows a tick landing on the same edge
  assign restart  = wr_count || (wr_ctrl && write_data[CTRL_EN_BIT] && !en_q);
  assign tick_eff = tick && !wr_count && !(wr_ctrl && !write_data[CTRL_EN_BIT]);

  timer_prescaler #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .enable  (en_q),
    .restart (restart),
    .div     (div_q),
    .tick    (tick)
  );

  always_comb begin
    en_d     = en_q;
    auto_d   = auto_q;
    ien_d    = ien_q;
    div_d    = div_q;
    period_d = period_q;
    count_d  = count_q;
    match_d  = match_q;
    ovr_d    = ovr_q;

    if (wr_status) begin
      match_d = match_q && !write_data[STATUS_MATCH_BIT];
      ovr_d   = ovr_q && !write_data[STATUS_OVR_BIT];
    end

    // Hardware sets land after W1C so a coincident set survives the clear
    if (tick_eff) begin
      if (count_q == period_q) begin
        match_d = 1'b1;
        if (match_q) begin
          ovr_d = 1'b1;
        end
        if (auto_q) begin
          count_d = '0;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q + DATA_W'(1);
      end
    end

    if (wr_ctrl) begin
      en_d   = write_data[CTRL_EN_BIT];
      auto_d = write_data[CTRL_AUTO_BIT];
      ien_d  = write_data[CTRL_IEN_BIT];
      div_d  = write_data[DIV_MSB:DIV_LSB];
    end
    if (wr_period) begin
      period_d = write_data;
    end
    if (wr_count) begin
      count_d = write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ien_q    <= 1'b0;
      div_q    <= '0;
      period_q <= '0;
      count_q  <= '0;
      match_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      ien_q    <= ien_d;
      div_q    <= div_d;
      period_q <= period_d;
      count_q  <= count_d;
      match_q  <= match_d;
      ovr_q    <= ovr_d;
    end
  end

  // Zero-latency read mux from registered state; returns pre-write values
  always_comb begin
    read_drive = sel && mem_read;
    read_data  = '0;
    if (read_drive) begin
      case (reg_idx)
        CTRL_IDX: begin
          read_data[CTRL_EN_BIT]     = en_q;
          read_data[CTRL_AUTO_BIT]   = auto_q;
          read_data[CTRL_IEN_BIT]    = ien_q;
          read_data[DIV_MSB:DIV_LSB] = div_q;
        end
        PERIOD_IDX: read_data = period_q;
        COUNT_IDX:  read_data = count_q;
        default: begin
          read_data[STATUS_MATCH_BIT] = match_q;
          read_data[STATUS_OVR_BIT]   = ovr_q;
        end
      endcase
    end
  end

  assign irq = match_q && ien_q;

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed self-checking bench for timer_peripheral: register access, prescaled
// counting, match/overrun, W1C races, wrap, decode bounds and mid-count reset.
module tb_timer_peripheral;

  localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
  localparam logic [63:0] CTRL = BASE;
  localparam logic [63:0] PER  = BASE + 64'h08;
  localparam logic [63:0] CNT  = BASE + 64'h10;
  localparam logic [63:0] STS  = BASE + 64'h18;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] address;
  logic [63:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] read_data;
  logic        read_drive;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] d;
  logic        drv;

  timer_peripheral dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .write_data (write_data),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .read_data  (read_data),
    .read_drive (read_drive),
    .irq        (irq)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] v);
    @(negedge clock);
    address    = a;
    write_data = v;
    mem_write  = 1'b1;
    mem_read   = 1'b0;
    @(posedge clock);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] v, output logic dv);
    address  = a;
    mem_read = 1'b1;
    #1;
    v        = read_data;
    dv       = read_drive;
    mem_read = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 64'(i * 8), d, drv);
      checks++;
      if (d !== 64'h0) begin errors++; $display("FAIL reset_read[%0d] got %h exp 0", i, d); end
      checks++;
      if (drv !== 1'b1) begin errors++; $display("FAIL reset_drive[%0d] got %b exp 1", i, drv); end
    end
    address  = CNT;
    mem_read = 1'b0;
    #1;
    checks++;
    if (read_drive !== 1'b0 || read_data !== 64'h0) begin
      errors++; $display("FAIL idle_bus got drive=%b data=%h exp 0/0", read_drive, read_data);
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
  endtask

  task automatic test_auto();
    do_reset();
    wr(PER, 64'd3);
    wr(CTRL, 64'h3);
    for (int i = 1; i <= 3; i++) begin
      step(1);
      rd(CNT, d, drv);
      checks++;
      if (d !== 64'(i)) begin errors++; $display("FAIL auto_count[%0d] got %h exp %h", i, d, 64'(i)); end
    end
    step(1);
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL auto_match1 got %h exp 1", d); end
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL auto_count_wrap got %h exp 0", d); end
    step(4);
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h3) begin errors++; $display("FAIL auto_ovr got %h exp 3", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL auto_irq_masked got %b exp 0", irq); end
    wr(STS, 64'h2);
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL ovr_w1c got %h exp 1", d); end
  endtask

  task automatic test_oneshot_div();
    do_reset();
    wr(PER, 64'd1);
    wr(CTRL, 64'h0002_0001);
    step(2);
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL div_count_e2 got %h exp 0", d); end
    step(1);
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL div_count_e3 got %h exp 1", d); end
    step(2);
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL div_nomatch_e5 got %h exp 0", d); end
    step(1);
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL div_match_e6 got %h exp 1", d); end
    rd(CTRL, d, drv);
    checks++;
    if (d !== 64'h0002_0000) begin errors++; $display("FAIL oneshot_en_clear got %h exp 20000", d); end
    step(3);
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL oneshot_hold got %h exp 1", d); end
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL oneshot_no_ovr got %h exp 1", d); end
  endtask

  task automatic test_w1c();
    do_reset();
    wr(PER, 64'd3);
    wr(CTRL, 64'h7);
    step(4);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_on_match got %b exp 1", irq); end
    wr(STS, 64'h1);
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL w1c_clear got %h exp 0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %b exp 1->0", irq); end
    step(2);
    wr(STS, 64'h1);
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL w1c_vs_set got %h exp 1", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_race got %b exp 1", irq); end
  endtask

  task automatic test_wrap();
    do_reset();
    wr(CNT, 64'hFFFF_FFFF_FFFF_FFFE);
    wr(CTRL, 64'h1);
    step(1);
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_max got %h exp ffffffffffffffff", d); end
    step(1);
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", d); end
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL wrap_nomatch got %h exp 0", d); end
    step(1);
    rd(STS, d, drv);
    checks++;
    if (d !== 64'h1) begin errors++; $display("FAIL wrap_match got %h exp 1", d); end
  endtask

  task automatic test_decode();
    do_reset();
    wr(64'h0000_0000_0001_0020, 64'h5);
    wr(64'h0000_0000_0000_FFF8, 64'h5);
    rd(64'h0000_0000_0001_0020, d, drv);
    checks++;
    if (drv !== 1'b0 || d !== 64'h0) begin errors++; $display("FAIL above_window got drive=%b data=%h exp 0/0", drv, d); end
    rd(64'h0000_0000_0000_FFF8, d, drv);
    checks++;
    if (drv !== 1'b0 || d !== 64'h0) begin errors++; $display("FAIL below_window got drive=%b data=%h exp 0/0", drv, d); end
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 64'(i * 8), d, drv);
      checks++;
      if (d !== 64'h0) begin errors++; $display("FAIL decode_untouched[%0d] got %h exp 0", i, d); end
    end
    wr(64'h0000_0000_0001_000D, 64'hABCD);
    rd(64'h0000_0000_0001_000F, d, drv);
    checks++;
    if (d !== 64'hABCD) begin errors++; $display("FAIL low_bits_ignored got %h exp abcd", d); end
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL period_no_count got %h exp 0", d); end
  endtask

  task automatic test_rw_same();
    do_reset();
    wr(CNT, 64'h7);
    @(negedge clock);
    address    = CNT;
    write_data = 64'h55;
    mem_write  = 1'b1;
    mem_read   = 1'b1;
    #1;
    checks++;
    if (read_data !== 64'h7) begin errors++; $display("FAIL rw_prewrite got %h exp 7", read_data); end
    @(posedge clock);
    #1;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'h55) begin errors++; $display("FAIL rw_postwrite got %h exp 55", d); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(PER, 64'd5);
    wr(CTRL, 64'h7);
    step(2);
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'h2) begin errors++; $display("FAIL mid_count got %h exp 2", d); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 64'(i * 8), d, drv);
      checks++;
      if (d !== 64'h0) begin errors++; $display("FAIL mid_reset[%0d] got %h exp 0", i, d); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got %b exp 0", irq); end
    reset = 1'b0;
    step(2);
    rd(CNT, d, drv);
    checks++;
    if (d !== 64'h0) begin errors++; $display("FAIL post_reset_idle got %h exp 0", d); end
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    write_data = '0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_auto();
    test_oneshot_div();
    test_w1c();
    test_wrap();
    test_decode();
    test_rw_same();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_peripheral.md
Name: timer_peripheral

Overview:
Memory-mapped timer peripheral that answers the processor's load/store data bus as a bus responder. The datapath issues the address, write data and read/write strobes; this block decodes its 32-byte window, holds four 64-bit registers, counts prescaled ticks, and raises a match interrupt. It is the first block to fill the processor's peripheral slot and sits beside data memory on the same bus.

Parameters:
BASE_ADDR, 64'h0000_0000_0001_0000, window base; must be 32-byte aligned.
PRESCALE_WIDTH, 16, width of the prescale divisor field and the prescale counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
address  input  64  byte address from the datapath.
write_data  input  64  store data from the datapath.
mem_write  input  1  store strobe, valid for the current cycle.
mem_read  input  1  load strobe, valid for the current cycle.
read_data  output  64  load data; 0 when not driving.
read_drive  output  1  high when this block owns the read bus (select & mem_read).
irq  output  1  interrupt request, level.

Behaviour:
- One clock, named clock; reset is synchronous and active-high, named reset. Reset is the only initialisation.
- select = (address[63:5] == BASE_ADDR[63:5]). address[2:0] is ignored, and the register is chosen by address[4:3].
- Registers: 0x00 CTRL holds bit0 EN, bit1 AUTO, bit2 IEN, and the [15+PRESCALE_WIDTH:16] DIV field. 0x08 PERIOD. 0x10 COUNT. 0x18 STATUS holds bit0 MATCH and bit1 OVR. Unused bits read 0 and ignore writes.
- Reset: all registers 0, prescale counter 0, read_data 0, read_drive 0, irq 0. Reset mid-count abandons the count with no residual flag.
- Reads are combinational with zero latency, because the datapath is single-cycle. When read_drive is high, read_data is the selected register; otherwise read_data is 0.
- Writes take effect at the clock edge when select & mem_write. CTRL, PERIOD and COUNT are full write. STATUS is write-1-to-clear.
- If mem_read and mem_write are both high, the read returns the pre-write value.
- Prescaler:
  - While EN is set, pre increments each cycle.
  - When pre == DIV, a tick is generated and pre returns to 0. This gives a tick every DIV+1 cycles.
  - While EN is clear, pre holds at 0.
  - An EN 0->1 write clears pre.
- On each tick:
  - If COUNT == PERIOD, set MATCH. If MATCH was already set, also set OVR. Then, if AUTO is set, COUNT <= 0. Otherwise COUNT holds at PERIOD and EN clears.
  - Otherwise COUNT <= COUNT+1, with modulo-2^64 wrap (0xFFFF_FFFF_FFFF_FFFF -> 0). If COUNT > PERIOD, the count wraps and then reaches PERIOD.
- Match period is PERIOD+1 ticks. PERIOD = 0 matches on every tick.
- Simultaneous events:
  - A COUNT write on a tick cycle: the write wins and pre clears.
  - A STATUS W1C on the same edge as a hardware set: the set wins.
  - A PERIOD write never alters COUNT. The new value is compared from the next tick onward.
  - A CTRL write clearing EN on a tick cycle: the tick is discarded.
- irq = MATCH & IEN, driven combinationally from registered state, so it has no glitch source beyond the registers.

Decomposition:
- Package timer_pkg holds the register offsets (CTRL_OFF, PERIOD_OFF, COUNT_OFF, STATUS_OFF), the CTRL and STATUS bit positions, and the DIV field bounds.
- Sub-module timer_prescaler has ports clock, reset, enable, restart, div, and tick out. The top holds decode, the registers, compare logic and the read mux.

Test Plan:
- Reset then read all four offsets at 0x10000..0x10018 -> read_data 0 each, read_drive 1 only during mem_read, and irq 0.
- Write PERIOD=3 and CTRL=0x3 (EN, AUTO, DIV=0) -> COUNT reads 1, 2, 3 on successive cycles. MATCH is set 4 edges after the CTRL write and COUNT returns to 0. MATCH repeats every 4 cycles, and OVR sets on the second match if MATCH is not cleared.
- With CTRL DIV=2 (0x0002_0001) and PERIOD=1, one-shot -> COUNT advances every 3 cycles. MATCH sets 6 edges after the write, EN reads 0 afterwards, and COUNT holds at 1.
- With IEN set and MATCH=1, write STATUS=0x1 on a non-match cycle -> MATCH=0 and irq drops the next cycle. Repeat the W1C coinciding with a match edge -> MATCH remains 1.
- Write COUNT=0xFFFF_FFFF_FFFF_FFFE with PERIOD=0 and EN, DIV=0 -> COUNT goes ...FFFF, then 0. MATCH sets on the tick at COUNT=0.
- Access at address 0x10020 or 0x0FFF8 -> no register changes and read_drive stays 0. Assert reset mid-count -> all registers 0 on the next edge.
